fb_paint_scheduler: RTL and testbench

- Sequences all writes into the single-port pixel framebuffer.
- Accepts brush "stamp" requests (BOX_W x BOX_H rectangle at a given origin and colour) and full-screen clear requests.
- Issues writes one pixel per cycle, and only while the VGA timing is in blanking, so that active-video reads never collide with writes.
- Sits between the paint input logic (brush position and colour) and the framebuffer RAM write port.

---
 rtl/fb_paint_scheduler.sv | 144 ++++++++++++++
 tb/tb_fb_paint_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_paint_scheduler.sv
// Framebuffer write sequencer: paints BOX_W x BOX_H brush stamps and full-screen
// clears, issuing one registered pixel write per cycle only during blanking.
module fb_paint_scheduler #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int BOX_W  = 10,
    parameter int BOX_H  = 10,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              video_on,
    input  logic              stamp_valid,
    output logic              stamp_ready,
    input  logic [9:0]        stamp_x,
    input  logic [9:0]        stamp_y,
    input  logic [11:0]       stamp_color,
    input  logic              clear_req,
    input  logic [11:0]       clear_color,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_wdata,
    output logic              stamp_done,
    output logic              busy
);

    // Handshake: a stamp transfers on a rising clk edge where stamp_valid && stamp_ready;
    // a clear_req arriving in the same idle cycle takes priority and the stamp is not taken.
    typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(H_RES * V_RES - 1);

    state_t            state;
    state_t            state_next;
    logic              clear_pending;
    logic [11:0]       clear_col;
    logic [9:0]        sx;
    logic [9:0]        sy;
    logic [11:0]       scol;
    logic [5:0]        cx;
    logic [5:0]        cy;
    logic [ADDR_W-1:0] p;

    logic [10:0]       col;
    logic [10:0]       row;
    logic              in_bounds;
    logic              stamp_last;
    logic              clear_last;
    logic              accept;
    logic              start_clear;
    logic              clear_set;
    logic [ADDR_W-1:0] pix_addr;

    // 11-bit sums so origins near 1023 plus box offsets clip instead of wrapping
    assign col        = {1'b0, sx} + {5'b0, cx};
    assign row        = {1'b0, sy} + {5'b0, cy};
    assign in_bounds  = (col < 11'(H_RES)) && (row < 11'(V_RES));
    assign pix_addr   = ADDR_W'(row) * ADDR_W'(H_RES) + ADDR_W'(col);
    assign stamp_last = (cx == 6'(BOX_W - 1)) && (cy == 6'(BOX_H - 1));
    assign clear_last = (p == LAST_P);

    assign stamp_ready = (state == IDLE) && !clear_pending;
    assign busy        = (state != IDLE) || clear_pending;
    assign accept      = stamp_valid && stamp_ready && !clear_req;
    assign start_clear = (state == IDLE) && clear_pending;
    assign clear_set   = clear_req && !clear_pending && (state != CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_clear)  state_next = CLEAR;
                else if (accept)  state_next = STAMP;
            end
            STAMP: if (!video_on && stamp_last) state_next = IDLE;
            CLEAR: if (!video_on && clear_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_pending <= 1'b0;
            clear_col     <= '0;
            sx            <= '0;
            sy            <= '0;
            scol          <= '0;
            cx            <= '0;
            cy            <= '0;
            p             <= '0;
            fb_we         <= 1'b0;
            fb_addr       <= '0;
            fb_wdata      <= '0;
            stamp_done    <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            stamp_done <= 1'b0;

            // colour is captured only on the 0->1 transition of the pending flag
            if (clear_set) begin
                clear_pending <= 1'b1;
                clear_col     <= clear_color;
            end else if (start_clear) begin
                clear_pending <= 1'b0;
            end

            if (start_clear) p <= '0;

            if (accept) begin
                sx   <= stamp_x;
                sy   <= stamp_y;
                scol <= stamp_color;
                cx   <= '0;
                cy   <= '0;
            end

            if (state == STAMP && !video_on) begin
                fb_we      <= in_bounds;
                fb_addr    <= pix_addr;
                fb_wdata   <= scol;
                stamp_done <= stamp_last;
                if (cx == 6'(BOX_W - 1)) begin
                    cx <= '0;
                    cy <= cy + 6'd1;
                end else begin
                    cx <= cx + 6'd1;
                end
            end

            if (state == CLEAR && !video_on) begin
                fb_we    <= 1'b1;
                fb_addr  <= p;
                fb_wdata <= clear_col;
                p        <= p + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_paint_scheduler.sv
// Bench for fb_paint_scheduler: a full-size and a 16x8 instance share stimulus and are
// checked every cycle against a slot-index model plus directed literal expectations.
module tb_fb_paint_scheduler;

    localparam int BW = 10;
    localparam int BH = 10;
    localparam int AW = 19;

    logic        clk;
    logic        rst_n;
    logic        video_on;
    logic        stamp_valid;
    logic [9:0]  stamp_x;
    logic [9:0]  stamp_y;
    logic [11:0] stamp_color;
    logic        clear_req;
    logic [11:0] clear_color;
    logic        no_clear;

    logic          ready_o [2];
    logic          we_o    [2];
    logic [AW-1:0] addr_o  [2];
    logic [11:0]   wdata_o [2];
    logic          done_o  [2];
    logic          busy_o  [2];

    fb_paint_scheduler #(.H_RES(640), .V_RES(480), .BOX_W(BW), .BOX_H(BH), .ADDR_W(AW)) u_big (
        .clk(clk), .rst_n(rst_n), .video_on(video_on),
        .stamp_valid(stamp_valid), .stamp_ready(ready_o[0]),
        .stamp_x(stamp_x), .stamp_y(stamp_y), .stamp_color(stamp_color),
        .clear_req(no_clear), .clear_color(clear_color),
        .fb_we(we_o[0]), .fb_addr(addr_o[0]), .fb_wdata(wdata_o[0]),
        .stamp_done(done_o[0]), .busy(busy_o[0])
    );

    fb_paint_scheduler #(.H_RES(16), .V_RES(8), .BOX_W(BW), .BOX_H(BH), .ADDR_W(AW)) u_small (
        .clk(clk), .rst_n(rst_n), .video_on(video_on),
        .stamp_valid(stamp_valid), .stamp_ready(ready_o[1]),
        .stamp_x(stamp_x), .stamp_y(stamp_y), .stamp_color(stamp_color),
        .clear_req(clear_req), .clear_color(clear_color),
        .fb_we(we_o[1]), .fb_addr(addr_o[1]), .fb_wdata(wdata_o[1]),
        .stamp_done(done_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // model: each job is a numbered list of write slots; slot n of a stamp is pixel
    // (n % BW, n / BW) of the box, slot n of a clear is address n
    int   m_st   [2];   // 0 idle, 1 stamp, 2 clear
    int   m_pend [2];
    int   m_n    [2];
    int   m_x    [2];
    int   m_y    [2];
    int   m_col  [2];
    int   m_ccol [2];
    int   exp_we   [2];
    int   exp_addr [2];
    int   exp_data [2];
    int   exp_done [2];
    bit   vo_edge;

    function automatic int hres(input int k); return (k == 0) ? 640 : 16; endfunction
    function automatic int vres(input int k); return (k == 0) ? 480 : 8;  endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_pend[k] = 0; m_n[k] = 0;
            exp_we[k] = 0; exp_done[k] = 0;
        end
        vo_edge = 1'b0;
    endtask

    task automatic model_step(input int k, input bit cr);
        int c;
        int r;
        exp_we[k]   = 0;
        exp_done[k] = 0;
        case (m_st[k])
            0: begin
                if (m_pend[k] != 0) begin
                    m_st[k] = 2; m_n[k] = 0; m_pend[k] = 0;
                end else if (cr) begin
                    m_pend[k] = 1; m_ccol[k] = int'(clear_color);
                end else if (stamp_valid) begin
                    m_st[k] = 1; m_n[k] = 0;
                    m_x[k] = int'(stamp_x); m_y[k] = int'(stamp_y); m_col[k] = int'(stamp_color);
                end
            end
            1: begin
                if (cr && m_pend[k] == 0) begin
                    m_pend[k] = 1; m_ccol[k] = int'(clear_color);
                end
                if (!video_on) begin
                    c = m_x[k] + m_n[k] % BW;
                    r = m_y[k] + m_n[k] / BW;
                    exp_we[k]   = (c < hres(k) && r < vres(k)) ? 1 : 0;
                    exp_addr[k] = r * hres(k) + c;
                    exp_data[k] = m_col[k];
                    m_n[k]++;
                    if (m_n[k] == BW * BH) begin
                        m_st[k] = 0; exp_done[k] = 1;
                    end
                end
            end
            default: begin
                if (!video_on) begin
                    exp_we[k] = 1; exp_addr[k] = m_n[k]; exp_data[k] = m_ccol[k];
                    m_n[k]++;
                    if (m_n[k] == hres(k) * vres(k)) m_st[k] = 0;
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0, 1'b0);
                model_step(1, clear_req);
                vo_edge = video_on;
            end
        end
    end

    int log_a0 [$];
    int log_d0 [$];
    int log_a1 [$];
    int log_d1 [$];
    int ref_a  [$];
    int done_cnt [2];

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("fb_we[%0d]", k), int'(we_o[k]), exp_we[k]);
                chk($sformatf("stamp_done[%0d]", k), int'(done_o[k]), exp_done[k]);
                chk($sformatf("stamp_ready[%0d]", k), int'(ready_o[k]),
                    (m_st[k] == 0 && m_pend[k] == 0) ? 1 : 0);
                chk($sformatf("busy[%0d]", k), int'(busy_o[k]),
                    (m_st[k] != 0 || m_pend[k] != 0) ? 1 : 0);
                if (exp_we[k] != 0) begin
                    chk($sformatf("fb_addr[%0d]", k), int'(addr_o[k]), exp_addr[k]);
                    chk($sformatf("fb_wdata[%0d]", k), int'(wdata_o[k]), exp_data[k]);
                end
                if (vo_edge) chk($sformatf("we_after_video[%0d]", k), int'(we_o[k]), 0);
                if (we_o[k]) begin
                    if (k == 0) begin log_a0.push_back(int'(addr_o[0])); log_d0.push_back(int'(wdata_o[0])); end
                    else        begin log_a1.push_back(int'(addr_o[1])); log_d1.push_back(int'(wdata_o[1])); end
                end
                if (done_o[k]) done_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_a0.delete(); log_d0.delete(); log_a1.delete(); log_d1.delete();
    endtask

    task automatic wait_done(input int k, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt[k] == base && n < budget) begin
            step();
            stamp_valid = 1'b0;
            n++;
        end
        chk($sformatf("done_seen[%0d]", k), done_cnt[k] - base, 1);
    endtask

    initial begin
        int base;
        int errs;
        int n;
        int busy_drop;
        int sz;
        int a;

        rst_n = 1'b0; video_on = 1'b0; stamp_valid = 1'b0; stamp_x = '0; stamp_y = '0;
        stamp_color = '0; clear_req = 1'b0; clear_color = '0; no_clear = 1'b0;

        // reset and idle
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_we[%0d]", k), int'(we_o[k]), 0);
            chk($sformatf("rst_addr[%0d]", k), int'(addr_o[k]), 0);
            chk($sformatf("rst_wdata[%0d]", k), int'(wdata_o[k]), 0);
            chk($sformatf("rst_done[%0d]", k), int'(done_o[k]), 0);
        end
        rst_n = 1'b1;
        repeat (20) step();
        chk("idle_ready", int'(ready_o[0]), 1);
        chk("idle_busy", int'(busy_o[0]), 0);
        chk("idle_writes", log_a0.size() + log_a1.size(), 0);

        // basic stamp
        clear_logs();
        base = done_cnt[0];
        stamp_valid = 1'b1; stamp_x = 10'd100; stamp_y = 10'd50; stamp_color = 12'hF00;
        wait_done(0, base, 300);
        chk("basic_ready_after_done", int'(ready_o[0]), 1);
        chk("basic_count", log_a0.size(), 100);
        chk("basic_first", (log_a0.size() > 0) ? log_a0[0] : -1, 32100);
        chk("basic_last", (log_a0.size() > 0) ? log_a0[log_a0.size() - 1] : -1, 37869);
        errs = 0;
        for (int i = 0; i < log_a0.size(); i++) begin
            if (log_d0[i] != 12'hF00) errs++;
            if (i > 0 && log_a0[i] - log_a0[i-1] != ((i % 10 == 0) ? 631 : 1)) errs++;
        end
        chk("basic_data_and_steps", errs, 0);
        repeat (5) step();
        chk("basic_single_done", done_cnt[0] - base, 1);
        ref_a = log_a0;

        // blanking gating: 5 cycles active / 5 blank
        clear_logs();
        base = done_cnt[0];
        n = 0;
        while (done_cnt[0] == base && n < 600) begin
            step();
            video_on = ((n / 5) % 2) == 1;
            stamp_valid = (n == 0);
            n++;
        end
        video_on = 1'b0; stamp_valid = 1'b0;
        chk("gate_done", done_cnt[0] - base, 1);
        chk("gate_count", log_a0.size(), 100);
        errs = 0;
        for (int i = 0; i < log_a0.size() && i < ref_a.size(); i++)
            if (log_a0[i] != ref_a[i]) errs++;
        chk("gate_sequence", errs, 0);
        repeat (5) step();

        // clipping at the bottom-right corner
        clear_logs();
        base = done_cnt[0];
        stamp_valid = 1'b1; stamp_x = 10'd635; stamp_y = 10'd475; stamp_color = 12'h0F0;
        n = 0;
        do begin
            step();
            stamp_valid = 1'b0;
            n++;
        end while (done_cnt[0] == base && n < 400);
        chk("clip_cycles", n, 101);
        chk("clip_count", log_a0.size(), 25);
        errs = 0;
        for (int i = 0; i < 25 && i < log_a0.size(); i++) begin
            a = (475 + i / 5) * 640 + 635 + i % 5;
            if (log_a0[i] != a || log_d0[i] != 12'h0F0) errs++;
        end
        chk("clip_addrs", errs, 0);
        repeat (5) step();

        // clear priority on the 16x8 instance with a stamp request held throughout
        clear_logs();
        base = done_cnt[1];
        stamp_valid = 1'b1; stamp_x = 10'd3; stamp_y = 10'd2; stamp_color = 12'hABC;
        clear_color = 12'h000;
        busy_drop = 0;
        n = 0;
        while (done_cnt[1] - base < 2 && n < 1000) begin
            step();
            n++;
            clear_req = (n == 30);
            if (log_a1.size() < 188 && !busy_o[1]) busy_drop++;
        end
        stamp_valid = 1'b0; clear_req = 1'b0;
        chk("prio_dones", done_cnt[1] - base, 2);
        chk("prio_busy_drop", busy_drop, 0);
        chk("prio_count", log_a1.size(), 248);
        errs = 0;
        for (int i = 0; i < log_a1.size(); i++) begin
            if (i < 60 || i >= 188) begin
                a = (2 + ((i < 60) ? i : i - 188) / 10) * 16 + 3 + ((i < 60) ? i : i - 188) % 10;
                if (log_a1[i] != a || log_d1[i] != 12'hABC) errs++;
            end else if (log_a1[i] != i - 60 || log_d1[i] != 0) begin
                errs++;
            end
        end
        chk("prio_sequence", errs, 0);
        repeat (150) step();

        // asynchronous reset in the middle of a clear
        clear_logs();
        clear_req = 1'b1; clear_color = 12'h5A5;
        step();
        clear_req = 1'b0;
        n = 0;
        while (log_a1.size() < 41 && n < 400) begin
            step();
            n++;
        end
        chk("mid_clear_addr", (log_a1.size() > 40) ? log_a1[40] : -1, 40);
        chk("mid_clear_we", int'(we_o[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_we_small", int'(we_o[1]), 0);
        chk("async_we_big", int'(we_o[0]), 0);
        chk("async_busy", int'(busy_o[1]), 0);
        step();
        step();
        rst_n = 1'b1;
        sz = log_a1.size();
        chk("writes_before_rst", sz, 41);
        repeat (60) step();
        chk("no_resume", log_a1.size(), sz);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            video_on    = ($urandom_range(0, 3) == 0);
            stamp_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: begin stamp_x = 10'($urandom_range(0, 20));    stamp_y = 10'($urandom_range(0, 12)); end
                1: begin stamp_x = 10'($urandom_range(620, 650)); stamp_y = 10'($urandom_range(460, 490)); end
                2: begin stamp_x = 10'($urandom_range(0, 1023));  stamp_y = 10'($urandom_range(0, 1023)); end
                default: begin stamp_x = 10'($urandom_range(0, 639)); stamp_y = 10'($urandom_range(0, 479)); end
            endcase
            stamp_color = 12'($urandom_range(0, 4095));
            clear_req   = ($urandom_range(0, 99) == 0);
            clear_color = 12'($urandom_range(0, 4095));
        end
        stamp_valid = 1'b0; clear_req = 1'b0; video_on = 1'b0;
        n = 0;
        while ((busy_o[0] || busy_o[1]) && n < 600) begin
            step();
            n++;
        end
        chk("final_idle_big", int'(busy_o[0]), 0);
        chk("final_idle_small", int'(busy_o[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
